// File: rtl/fpu_addsub_arbiter.sv
// Round-robin front end that shares one multi-cycle FP16 add/sub unit among N_REQ requesters.
// The unit is held in reset except while an operation is in flight; a watchdog forces a response if it hangs.
module fpu_addsub_arbiter #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [16*N_REQ-1:0]  req_x,
    input  logic [16*N_REQ-1:0]  req_y,
    input  logic [N_REQ-1:0]     req_sub,
    output logic [N_REQ-1:0]     rsp_valid,
    input  logic [N_REQ-1:0]     rsp_ready,
    output logic [15:0]          rsp_result,
    output logic [1:0]           rsp_ofuf,
    output logic                 rsp_timeout,
    output logic                 busy,
    output logic                 fu_reset,
    output logic [15:0]          fu_x,
    output logic [15:0]          fu_y,
    output logic                 fu_addsub,
    input  logic                 fu_done,
    input  logic [15:0]          fu_result,
    input  logic [1:0]           fu_ofuf
);

    localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [PW-1:0]   r_ptr;
    logic [PW-1:0]   r_g;
    logic [15:0]     r_x;
    logic [15:0]     r_y;
    logic            r_sub;
    logic [15:0]     r_result;
    logic [1:0]      r_ofuf;
    logic            r_timeout;
    logic [TW-1:0]   r_timer;

    logic            w_found;
    logic [PW-1:0]   w_win;
    logic [PW-1:0]   w_idx;
    logic            w_accept;
    logic            w_expire;

    // Search upward from the requester after the last one served.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            w_idx = PW'((32'(r_ptr) + k) % N_REQ);
            if (!w_found && req_valid[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    assign w_accept = (r_state == S_IDLE) && w_found && !reset;
    assign w_expire = (r_timer == TW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        req_ready = '0;
        rsp_valid = '0;
        busy      = (r_state != S_IDLE);
        fu_reset  = (r_state != S_WAIT);
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    req_ready[w_win] = 1'b1;
                    w_next           = S_ISSUE;
                end
            end
            S_ISSUE: w_next = S_WAIT;
            S_WAIT: begin
                if (fu_done || w_expire) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid[r_g] = 1'b1;
                if (rsp_ready[r_g]) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr     <= PW'(N_REQ - 1);
            r_g       <= '0;
            r_x       <= '0;
            r_y       <= '0;
            r_sub     <= 1'b0;
            r_result  <= '0;
            r_ofuf    <= '0;
            r_timeout <= 1'b0;
            r_timer   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_x   <= req_x[16*w_win +: 16];
                        r_y   <= req_y[16*w_win +: 16];
                        r_sub <= req_sub[w_win];
                        r_g   <= w_win;
                    end
                end
                S_ISSUE: r_timer <= '0;
                S_WAIT: begin
                    // A completion on the expiry cycle still counts as a real result.
                    if (fu_done) begin
                        r_result  <= fu_result;
                        r_ofuf    <= fu_ofuf;
                        r_timeout <= 1'b0;
                    end else if (w_expire) begin
                        r_result  <= '0;
                        r_ofuf    <= '0;
                        r_timeout <= 1'b1;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready[r_g]) begin
                        r_ptr <= r_g;
                    end
                end
                default: ;
            endcase
        end
    end

    assign fu_x        = r_x;
    assign fu_y        = r_y;
    assign fu_addsub   = r_sub;
    assign rsp_result  = r_result;
    assign rsp_ofuf    = r_ofuf;
    assign rsp_timeout = r_timeout;

endmodule

// File: tb/tb_fpu_addsub_arbiter.sv
// Scoreboard bench for fpu_addsub_arbiter: a behavioural unit model, a transaction-level
// arbitration/latency reference, and a negedge monitor that pops expected responses.
module tb_fpu_addsub_arbiter;

    localparam int N  = 4;
    localparam int TO = 64;

    logic               clk = 1'b0;
    logic               reset;
    logic [N-1:0]       req_valid, req_ready, req_sub, rsp_valid, rsp_ready;
    logic [16*N-1:0]    req_x, req_y;
    logic [15:0]        rsp_result, fu_x, fu_y, fu_result;
    logic [1:0]         rsp_ofuf, fu_ofuf;
    logic               rsp_timeout, busy, fu_reset, fu_addsub, fu_done;

    always #5 clk = ~clk;

    fpu_addsub_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_sub(req_sub),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_ofuf(rsp_ofuf), .rsp_timeout(rsp_timeout),
        .busy(busy), .fu_reset(fu_reset), .fu_x(fu_x), .fu_y(fu_y),
        .fu_addsub(fu_addsub), .fu_done(fu_done), .fu_result(fu_result), .fu_ofuf(fu_ofuf)
    );

    // Unit latency in WAIT cycles: 0xFEkk operands encode kk directly (used for hangs/boundaries).
    function automatic int lat_of(logic [15:0] x, logic [15:0] y);
        if (x[15:8] == 8'hFE) return int'(x[7:0]);
        if (x == 16'h3C00 && y == 16'h3C00) return 3;
        return int'(y[2:0]);
    endfunction

    function automatic logic [17:0] fu_ref(logic [15:0] x, logic [15:0] y, logic sub);
        logic [15:0] r;
        if (!sub && x == 16'h3C00 && y == 16'h3C00) return {2'b00, 16'h4000};
        if (sub && x == 16'h4200 && y == 16'h3C00) return {2'b00, 16'h4000};
        r = sub ? x - y : x + y;
        return {x[15] ^ y[15], r[15], r};
    endfunction

    function automatic logic [N-1:0] oh(int g);
        logic [N-1:0] v;
        v = '0;
        v[g] = 1'b1;
        return v;
    endfunction

    // Unit model: asserts a stale done with junk data whenever held in reset.
    int fu_cnt = 0;
    always @(posedge clk) fu_cnt <= fu_reset ? 0 : fu_cnt + 1;
    always_comb begin
        fu_done   = 1'b0;
        fu_result = 16'hBAD1;
        fu_ofuf   = 2'b10;
        if (fu_reset) begin
            fu_done   = 1'b1;
            fu_result = 16'hBAD0;
            fu_ofuf   = 2'b11;
        end else if (fu_cnt == lat_of(fu_x, fu_y)) begin
            fu_done = 1'b1;
            {fu_ofuf, fu_result} = fu_ref(fu_x, fu_y, fu_addsub);
        end
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          g;
        logic [15:0] x, y;
        logic        sub;
        logic [15:0] res;
        logic [1:0]  ofuf;
        logic        to;
        int          acc_cyc;
        int          rsp_cyc;
    } exp_t;

    exp_t q[$];
    exp_t cur, hold, e;
    int   acc_log[$];
    logic m_busy = 1'b0, m_inresp = 1'b0, post_reset = 1'b0;
    int   m_ptr = N - 1;
    int   win, lat;
    logic [N-1:0]  exp_rdy;
    logic [17:0]   r18;

    always @(negedge clk) begin
        if (reset) begin
            chk("ready_in_reset", req_ready, '0);
            m_busy = 1'b0; m_inresp = 1'b0; m_ptr = N - 1;
            q.delete();
            post_reset = 1'b1;
        end else begin
            if (post_reset) begin
                chk("rst_busy", busy, 1'b0);
                chk("rst_rsp_valid", rsp_valid, '0);
                chk("rst_fu_reset", fu_reset, 1'b1);
                chk("rst_fu_x", fu_x, '0);
                chk("rst_fu_y", fu_y, '0);
                chk("rst_fu_addsub", fu_addsub, 1'b0);
                chk("rst_result", rsp_result, '0);
                chk("rst_timeout", rsp_timeout, 1'b0);
                post_reset = 1'b0;
            end
            win = -1;
            if (!m_busy)
                for (int k = 1; k <= N; k++)
                    if (win < 0 && req_valid[(m_ptr + k) % N]) win = (m_ptr + k) % N;
            exp_rdy = (win >= 0) ? oh(win) : '0;
            chk("req_ready", req_ready, exp_rdy);
            chk("busy", busy, m_busy);
            if (m_busy) begin
                chk("fu_x", fu_x, cur.x);
                chk("fu_y", fu_y, cur.y);
                chk("fu_addsub", fu_addsub, cur.sub);
                chk("fu_reset", fu_reset, !(cyc >= cur.acc_cyc + 2 && cyc < cur.rsp_cyc));
            end else begin
                chk("fu_reset_idle", fu_reset, 1'b1);
            end

            if (rsp_valid != '0) begin
                if (!m_inresp) begin
                    if (q.size() == 0) begin
                        chk("rsp_unexpected", rsp_valid, '0);
                    end else begin
                        hold = q.pop_front();
                        m_inresp = 1'b1;
                        chk("rsp_valid", rsp_valid, oh(hold.g));
                        chk("rsp_result", rsp_result, hold.res);
                        chk("rsp_ofuf", rsp_ofuf, hold.ofuf);
                        chk("rsp_timeout", rsp_timeout, hold.to);
                        chk("rsp_latency", cyc, hold.rsp_cyc);
                    end
                end else begin
                    chk("hold_valid", rsp_valid, oh(hold.g));
                    chk("hold_result", rsp_result, hold.res);
                    chk("hold_ofuf", rsp_ofuf, hold.ofuf);
                    chk("hold_timeout", rsp_timeout, hold.to);
                end
                if (m_inresp && rsp_ready[hold.g]) begin
                    m_ptr = hold.g; m_busy = 1'b0; m_inresp = 1'b0;
                end
            end else if (m_inresp) begin
                chk("rsp_dropped", rsp_valid, oh(hold.g));
                m_inresp = 1'b0; m_busy = 1'b0;
            end else if (q.size() != 0 && cyc > q[0].rsp_cyc) begin
                chk("rsp_missing", rsp_valid, oh(q[0].g));
                void'(q.pop_front());
                m_busy = 1'b0;
            end

            if (win >= 0) begin
                e.g   = win;
                e.x   = req_x[16*win +: 16];
                e.y   = req_y[16*win +: 16];
                e.sub = req_sub[win];
                lat   = lat_of(e.x, e.y);
                r18   = fu_ref(e.x, e.y, e.sub);
                e.acc_cyc = cyc;
                if (lat < TO) begin
                    e.res = r18[15:0]; e.ofuf = r18[17:16]; e.to = 1'b0;
                    e.rsp_cyc = cyc + 3 + lat;
                end else begin
                    e.res = '0; e.ofuf = '0; e.to = 1'b1;
                    e.rsp_cyc = cyc + 2 + TO;
                end
                q.push_back(e);
                cur = e;
                m_busy = 1'b1;
                acc_log.push_back(win);
            end
        end
    end

    // Driver state
    logic [15:0]  px [N];
    logic [15:0]  py [N];
    logic [N-1:0] pv = '0, ps = '0, rr = '1;
    logic         rst = 1'b1;
    int           phase = 0;
    int           seen = 0;

    task automatic new_op(input int i, input bit allow_long);
        px[i] = 16'($urandom);
        py[i] = 16'($urandom);
        ps[i] = 1'($urandom);
        if (px[i][15:8] == 8'hFE) px[i][15] = 1'b0;
        if (allow_long && $urandom_range(9, 0) == 0)
            case ($urandom_range(2, 0))
                0:       px[i] = 16'hFE3F;
                1:       px[i] = 16'hFE40;
                default: px[i] = 16'hFE64;
            endcase
        pv[i] = 1'b1;
    endtask

    task automatic rearm(input int g);
        case (phase)
            1: begin
                if (seen <= 4) new_op(g, 0);
                else if (seen == 5) pv[2] = 1'b0;
            end
            2: if ($urandom_range(1, 0) == 1) new_op(g, 1);
            default: ;
        endcase
    endtask

    task automatic drive();
        reset     = rst;
        req_valid = pv;
        req_sub   = ps;
        rsp_ready = rr;
        for (int i = 0; i < N; i++) begin
            req_x[16*i +: 16] = px[i];
            req_y[16*i +: 16] = py[i];
        end
    endtask

    task automatic step();
        drive();
        @(posedge clk);
        #1;
        while (seen < acc_log.size()) begin
            int g;
            g = acc_log[seen];
            seen++;
            pv[g] = 1'b0;
            rearm(g);
        end
    endtask

    task automatic wait_acc(input int n, input string nm);
        for (int k = 0; k < 400 && acc_log.size() < n; k++) step();
        chk(nm, 32'(acc_log.size() >= n), 1);
    endtask

    task automatic drain(input string nm);
        for (int k = 0; k < 2000 && (pv != '0 || m_busy || q.size() != 0); k++) step();
        chk(nm, {31'd0, m_busy}, 0);
    endtask

    int ord[7] = '{0, 1, 2, 3, 0, 1, 3};
    int n0;

    initial begin
        for (int i = 0; i < N; i++) begin px[i] = '0; py[i] = '0; end
        // Phase 1: all requesters valid from reset; rotation then a sparse pair.
        phase = 1;
        new_op(1, 0);
        new_op(3, 0);
        px[0] = 16'h3C00; py[0] = 16'h3C00; ps[0] = 1'b0; pv[0] = 1'b1;
        px[2] = 16'h4200; py[2] = 16'h3C00; ps[2] = 1'b1; pv[2] = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        wait_acc(7, "phase1_accepts");
        phase = 0;
        drain("phase1_drain");
        for (int k = 0; k < 7; k++)
            if (k < acc_log.size()) chk("grant_order", acc_log[k], ord[k]);

        // Phase 2: random traffic with random response back-pressure.
        phase = 2;
        for (int c = 0; c < 600; c++) begin
            rr = N'($urandom);
            for (int i = 0; i < N; i++)
                if (!pv[i] && $urandom_range(3, 0) == 0) new_op(i, 1);
            step();
        end
        phase = 0;
        rr = '1;
        drain("phase2_drain");

        // Phase 3: response stalled while other requests pend.
        for (int i = 0; i < N; i++) new_op(i, 0);
        rr = '0;
        for (int k = 0; k < 150 && rsp_valid == '0; k++) step();
        chk("stall_rsp_seen", 32'(rsp_valid != '0), 1);
        repeat (5) step();
        rr = '1;
        drain("phase3_drain");

        // Phase 4: watchdog expiry, done on the expiry cycle, then a normal op.
        new_op(1, 0); px[1] = 16'hFE40;
        new_op(2, 0); px[2] = 16'hFE3F;
        new_op(3, 0);
        drain("phase4_drain");

        // Phase 5: reset during WAIT discards the op; requester 0 wins next.
        n0 = acc_log.size();
        new_op(3, 0); px[3] = 16'hFEC8;
        wait_acc(n0 + 1, "phase5_accept");
        repeat (4) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < N; i++) new_op(i, 0);
        wait_acc(n0 + 2, "phase5_regrant");
        if (acc_log.size() > n0 + 1) chk("post_reset_grant", acc_log[n0 + 1], 0);
        drain("phase5_drain");
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

endmodule

// File: doc/fpu_addsub_arbiter.md
# fpu_addsub_arbiter

Shares one multi-cycle FP16 add/subtract unit among `N_REQ` requesters.
- Round-robin arbitration on requests; latches the winner's operands.
- Starts the unit by pulsing its synchronous reset, then waits for `done`.
- Returns result and overflow/underflow flags to the winning requester over a valid/ready response.
- Sits between the FPU issue logic and the add/sub datapath; includes a timeout watchdog so a hung unit cannot deadlock the FPU.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `TIMEOUT`, 64, max WAIT cycles before forced completion (≥4)
- `clk` in 1: single clock, rising edge
- `reset` in 1: synchronous, active-high
- `req_valid` in N_REQ: per-requester request
- `req_ready` out N_REQ: one-hot accept, combinational, IDLE only
- `req_x` in 16*N_REQ: operand X, slice i = [16i+15:16i]
- `req_y` in 16*N_REQ: operand Y, same packing
- `req_sub` in N_REQ: 0 = add, 1 = subtract
- `rsp_valid` out N_REQ: one-hot response valid to the granted requester
- `rsp_ready` in N_REQ: per-requester response accept
- `rsp_result` out 16: FP16 result
- `rsp_ofuf` out 2: unit OFUF flags
- `rsp_timeout` out 1: response was forced by the watchdog
- `busy` out 1: state ≠ IDLE
- `fu_reset` out 1: unit reset/start
- `fu_x` out 16: unit operand X
- `fu_y` out 16: unit operand Y
- `fu_addsub` out 1: unit operation select
- `fu_done` in 1: unit completion
- `fu_result` in 16: unit result
- `fu_ofuf` in 2: unit flags

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - Winner is the first asserted `req_valid` searching upward from `ptr+1` mod N_REQ.
  - `req_ready[winner]`=1; all other `req_ready` bits are 0.
  - On `req_valid & req_ready`: latch X, Y, sub and grant index g; go to ISSUE.
  - No valid request: stay in IDLE.
- **ISSUE** (exactly 1 cycle)
  - `fu_reset`=1 with operands driven.
  - Clear timer; go to WAIT.
- **WAIT**
  - `fu_reset`=0; timer increments each cycle.
  - `fu_done`=1: capture `fu_result`/`fu_ofuf`, set `rsp_timeout`=0, go to RESP.
  - Otherwise, timer == TIMEOUT-1: result=0x0000, ofuf=2'b00, `rsp_timeout`=1, go to RESP.
  - `fu_done` and timer expiry in the same cycle: `fu_done` wins (`rsp_timeout`=0).
- **RESP**
  - `rsp_valid[g]`=1; result, flags and timeout held stable.
  - On `rsp_ready[g]`: `ptr`<=g, go to IDLE.
  - `rsp_ready` bits of non-granted requesters are ignored.
- `fu_reset`=1 in every state except WAIT, so the unit is parked between operations.
- `fu_x`/`fu_y`/`fu_addsub` are driven from the operand registers at all times.
- `fu_done` is sampled only in WAIT; stale `done` from a previous op during IDLE/ISSUE is ignored.
- Timer: width $clog2(TIMEOUT); no wrap, because it is only compared in WAIT.
- `ptr` update: only on a completed response handshake, never on a timeout-free abort.

## Timing
- Reset (synchronous) puts these on the next edge:
  - state=IDLE, `ptr`=N_REQ-1 (requester 0 has first priority)
  - operand/result registers 0; `rsp_valid`=0, `rsp_timeout`=0, `busy`=0
  - `fu_reset`=1, `fu_x`=`fu_y`=0, `fu_addsub`=0
- Reset mid-operation (any state): in-flight op discarded, no response ever issued, `req_ready`=0 during the reset cycle.
- Latency: accept edge T0 → ISSUE in cycle T0+1 → WAIT from T0+2.
- `fu_done` seen in WAIT at cycle Tn → `rsp_valid` asserted at Tn+1.
- Minimum accept-to-`rsp_valid`: 3 cycles.
- Throughput: one op per (4 + unit latency + response stall) cycles; back-to-back accept is allowed in the cycle after the RESP handshake.
- `req_ready` depends combinationally on `req_valid` and state only; there is no combinational path from `rsp_ready` to `req_ready`.

## Test plan
- Req0 add, X=0x3C00, Y=0x3C00; model asserts `fu_done` 3 cycles into WAIT with 0x4000 → `fu_reset` high one ISSUE cycle; `rsp_valid`=4'b0001, `rsp_result`=0x4000, `rsp_ofuf`=0, `rsp_timeout`=0.
- All four `req_valid` high from reset, `rsp_ready` tied high → grant order 0,1,2,3,0. Then only req1 and req3 valid after grant to 3 → grant 1, then 3.
- Req2 subtract, X=0x4200, Y=0x3C00 → `fu_addsub`=1 throughout ISSUE/WAIT. Stale `fu_done`=1 held during ISSUE is ignored; a response appears only after `fu_done` in WAIT.
- `fu_done` never asserted, TIMEOUT=64 → `rsp_valid` exactly 64 WAIT cycles later, `rsp_result`=0x0000, `rsp_timeout`=1. Next request is served normally.
- `rsp_ready` low for 5 cycles in RESP with other requests pending → `rsp_valid`/`rsp_result` stable; `req_ready`=0 and `busy`=1 throughout.
- `reset` pulsed during WAIT → next cycle IDLE, `rsp_valid`=0, `fu_reset`=1; the discarded op never responds, and the next grant goes to requester 0 when all are valid.
